// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits byte/half/word accesses into little-endian byte beats
// on an 8-bit synchronous data memory and reassembles/extends the load result.
module mem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          size_reg, size_next;
  logic                unsigned_reg, unsigned_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [XLEN-1:0]     wdata_reg, wdata_next;
  logic [2:0]          beat_reg, beat_next;
  logic [1:0]          cur_idx_reg, cur_idx_next;
  logic                pend_reg, pend_next;
  logic [1:0]          cap_idx_reg, cap_idx_next;
  logic [7:0]          bytes_reg [4];
  logic [7:0]          bytes_next [4];

  logic                req_ready_reg, req_ready_next;
  logic                resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0]     resp_rdata_reg, resp_rdata_next;
  logic                resp_err_reg, resp_err_next;
  logic                mem_read_reg, mem_read_next;
  logic                mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [7:0]          mem_wdata_reg, mem_wdata_next;

  logic                accept, bad_req, fill;

  function automatic logic [2:0] beats(input logic [1:0] sz);
    case (sz)
      2'b00:   beats = 3'd1;
      2'b01:   beats = 3'd2;
      default: beats = 3'd4;
    endcase
  endfunction

  assign accept  = req_valid && req_ready_reg;
  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_next      = state_reg;
    size_next       = size_reg;
    unsigned_next   = unsigned_reg;
    base_next       = base_reg;
    wdata_next      = wdata_reg;
    beat_next       = beat_reg;
    cur_idx_next    = cur_idx_reg;
    pend_next       = mem_read_reg;
    cap_idx_next    = cur_idx_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = '0;
    resp_err_next   = 1'b0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_addr_next   = '0;
    mem_wdata_next  = 8'h00;
    fill            = 1'b0;

    // Read data arrives the cycle after its strobe; file it under the beat that requested it.
    bytes_next = bytes_reg;
    for (int i = 0; i < 4; i++) begin
      if (pend_reg && cap_idx_reg == 2'(i)) bytes_next[i] = mem_rdata;
    end

    case (state_reg)
      IDLE: begin
        if (accept) begin
          size_next     = req_size;
          unsigned_next = req_unsigned;
          base_next     = req_addr;
          wdata_next    = req_wdata;
          if (bad_req) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            beat_next     = 3'd1;
            cur_idx_next  = 2'd0;
            mem_addr_next = req_addr;
            if (req_write) begin
              mem_write_next = 1'b1;
              mem_wdata_next = req_wdata[7:0];
              state_next     = WR;
            end else begin
              mem_read_next = 1'b1;
              state_next    = RD;
            end
          end
        end
      end
      RD: begin
        if (beat_reg < beats(size_reg)) begin
          mem_read_next = 1'b1;
          mem_addr_next = base_reg + ADDR_W'(beat_reg);
          cur_idx_next  = beat_reg[1:0];
          beat_next     = beat_reg + 3'd1;
        end else begin
          state_next = RD_TAIL;
        end
      end
      RD_TAIL: begin
        state_next      = IDLE;
        resp_valid_next = 1'b1;
        case (size_reg)
          2'b00: begin
            fill            = ~unsigned_reg & bytes_next[0][7];
            resp_rdata_next = {{(XLEN-8){fill}}, bytes_next[0]};
          end
          2'b01: begin
            fill            = ~unsigned_reg & bytes_next[1][7];
            resp_rdata_next = {{(XLEN-16){fill}}, bytes_next[1], bytes_next[0]};
          end
          default: resp_rdata_next = XLEN'({bytes_next[3], bytes_next[2], bytes_next[1], bytes_next[0]});
        endcase
      end
      WR: begin
        if (beat_reg < beats(size_reg)) begin
          mem_write_next = 1'b1;
          mem_addr_next  = base_reg + ADDR_W'(beat_reg);
          mem_wdata_next = 8'(wdata_reg >> {beat_reg[1:0], 3'b000});
          beat_next      = beat_reg + 3'd1;
        end else begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      base_reg       <= '0;
      wdata_reg      <= '0;
      beat_reg       <= 3'd0;
      cur_idx_reg    <= 2'd0;
      pend_reg       <= 1'b0;
      cap_idx_reg    <= 2'd0;
      bytes_reg      <= '{default: 8'h00};
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= 8'h00;
    end else begin
      state_reg      <= state_next;
      size_reg       <= size_next;
      unsigned_reg   <= unsigned_next;
      base_reg       <= base_next;
      wdata_reg      <= wdata_next;
      beat_reg       <= beat_next;
      cur_idx_reg    <= cur_idx_next;
      pend_reg       <= pend_next;
      cap_idx_reg    <= cap_idx_next;
      bytes_reg      <= bytes_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign MemRead    = mem_read_reg;
  assign MemWrite   = mem_write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256x8 synchronous memory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  bit   [7:0]  mem [256];

  int          n_cmp = 0;
  int          n_err = 0;

  logic        rd_log [1:16];
  logic        wr_log [1:16];
  logic [7:0]  a_log  [1:16];
  logic [7:0]  d_log  [1:16];
  int          lat;
  logic [31:0] r_data;
  logic        r_err;
  logic        r_rdy;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (MemWrite) mem[mem_addr] <= mem_wdata;
    if (MemRead)  mem_rdata <= mem[mem_addr];
  end

  mem_access_unit #(.ADDR_W(8), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the unit is idle; returns at the negedge of the response cycle.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [7:0] a, input logic [31:0] wd);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    for (int c = 1; c <= 16; c++) begin
      rd_log[c] = 1'b0; wr_log[c] = 1'b0; a_log[c] = 8'h00; d_log[c] = 8'h00;
    end
    lat = 0;
    @(posedge clock);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      rd_log[c] = MemRead; wr_log[c] = MemWrite; a_log[c] = mem_addr; d_log[c] = mem_wdata;
      chk("no_strobe_overlap", {31'b0, MemRead & MemWrite}, 32'd0);
      if (c == 1) begin
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_size = ~sz; req_unsigned = ~u;
      end
      if (resp_valid) begin
        lat = c; r_data = resp_rdata; r_err = resp_err; r_rdy = req_ready;
        break;
      end
    end
    $display("txn w=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
             w, sz, u, a, wd, lat, r_data, r_err);
  endtask

  task automatic store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd,
                       input int nb);
    send(1'b1, sz, 1'b0, a, wd);
    chk("st_latency", lat, nb + 1);
    chk("st_err", {31'b0, r_err}, 32'd0);
    chk("st_rdata", r_data, 32'd0);
    chk("st_ready_in_resp", {31'b0, r_rdy}, 32'd1);
    for (int k = 0; k < nb; k++) begin
      chk("st_memwrite", {31'b0, wr_log[k+1]}, 32'd1);
      chk("st_addr", {24'b0, a_log[k+1]}, {24'b0, a + 8'(k)});
      chk("st_data", {24'b0, d_log[k+1]}, (wd >> (8*k)) & 32'hFF);
    end
    chk("st_no_memread", {31'b0, rd_log[1]}, 32'd0);
    chk("st_idle_strobe", {31'b0, wr_log[nb+1]}, 32'd0);
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [7:0] a,
                      input logic [31:0] exp, input int nb);
    send(1'b0, sz, u, a, 32'h0);
    chk("ld_latency", lat, nb + 2);
    chk("ld_rdata", r_data, exp);
    chk("ld_err", {31'b0, r_err}, 32'd0);
    for (int k = 0; k < nb; k++) begin
      chk("ld_memread", {31'b0, rd_log[k+1]}, 32'd1);
      chk("ld_addr", {24'b0, a_log[k+1]}, {24'b0, a + 8'(k)});
    end
    chk("ld_tail_strobe", {31'b0, rd_log[nb+1]}, 32'd0);
    chk("ld_tail_addr", {24'b0, a_log[nb+1]}, 32'd0);
    chk("ld_no_memwrite", {31'b0, wr_log[1]}, 32'd0);
  endtask

  task automatic bad(input logic w, input logic [1:0] sz, input logic [7:0] a);
    send(w, sz, 1'b0, a, 32'h1234_5678);
    chk("err_latency", lat, 1);
    chk("err_flag", {31'b0, r_err}, 32'd1);
    chk("err_rdata", r_data, 32'd0);
    chk("err_no_memread", {31'b0, rd_log[1]}, 32'd0);
    chk("err_no_memwrite", {31'b0, wr_log[1]}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_addr_data", {16'b0, mem_addr, mem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word round trip; every request below is issued in the previous response cycle.
    store(2'b10, 8'h10, 32'hDEAD_BEEF, 4);
    load(2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 4);

    store(2'b00, 8'h21, 32'h0000_0080, 1);
    load(2'b00, 1'b0, 8'h21, 32'hFFFF_FF80, 1);
    load(2'b00, 1'b1, 8'h21, 32'h0000_0080, 1);
    store(2'b01, 8'h20, 32'h0000_8001, 2);
    load(2'b01, 1'b0, 8'h20, 32'hFFFF_8001, 2);
    load(2'b01, 1'b1, 8'h20, 32'h0000_8001, 2);
    load(2'b00, 1'b0, 8'h20, 32'h0000_0001, 1);
    load(2'b10, 1'b1, 8'h10, 32'hDEAD_BEEF, 4);

    bad(1'b0, 2'b10, 8'h22);
    bad(1'b0, 2'b01, 8'h21);
    bad(1'b0, 2'b11, 8'h20);
    bad(1'b1, 2'b10, 8'h11);
    chk("err_mem_untouched", {24'b0, mem[8'h11]}, 32'h0000_00BE);

    store(2'b10, 8'hFC, 32'h1234_5678, 4);
    load(2'b10, 1'b0, 8'hFC, 32'h1234_5678, 4);
    chk("top_no_wrap", {24'b0, mem[8'h00]}, 32'd0);

    // Abort a word store with reset during its second beat.
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 8'h40;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort_beat0", {23'b0, MemWrite, mem_addr}, {23'b0, 1'b1, 8'h40});
    @(negedge clock);
    chk("abort_beat1", {23'b0, MemWrite, mem_addr}, {23'b0, 1'b1, 8'h41});
    reset = 1'b1;
    @(negedge clock);
    chk("abort_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("abort_resp", {31'b0, resp_valid}, 32'd0);
    chk("abort_ready_in_rst", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_after", {30'b0, resp_valid, MemWrite}, 32'd0);
    @(negedge clock);
    chk("abort_quiet", {29'b0, resp_valid, MemWrite, MemRead}, 32'd0);
    chk("abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0000_F00D);
    $display("txn aborted store at 40 -> mem[43:40]=%h%h%h%h",
             mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]);

    load(2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
